inst_cache: RTL and testbench
=============================

# inst_cache

Direct-mapped, read-only instruction cache that sits directly upstream of the pipelined datapath's fetch stage. It consumes the datapath's `inst_read`/`inst_addr` request and returns `inst_resp`/`inst_rdata`. Hits are answered in the request cycle. Misses fetch a full 256-bit line over a single-beat physical-memory port, under a two-state miss FSM. Hit and miss counters are exported for performance monitoring.

## Interface
Parameters:
- `S_INDEX`, default 4: index bits; number of sets = 2^S_INDEX.
- `S_TAG`, default 32-5-S_INDEX: tag width. The offset is fixed at 5 bits (32-byte line).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `inst_read` input 1: fetch request from the datapath.
- `inst_addr` input 32: fetch byte address.
- `inst_resp` output 1: requested word is valid this cycle.
- `inst_rdata` output 32: requested instruction word.
- `pmem_read` output 1: line-fill request to memory.
- `pmem_address` output 32: line-aligned fill address, with bits [4:0] = 0.
- `pmem_rdata` input 256: fill line data, valid with `pmem_resp`.
- `pmem_resp` input 1: fill complete; one-cycle pulse.
- `hit_count` output 32: saturating count of hit cycles.
- `miss_count` output 32: saturating count of misses.

## Operation
Address split:
- tag = `inst_addr[31:5+S_INDEX]`
- index = `inst_addr[4+S_INDEX:5]`
- word = `inst_addr[4:2]`
- `inst_addr[1:0]` is ignored.

Storage is flops. Each set holds one valid bit, a tag of S_TAG bits, and a 256-bit line. Word w occupies line bits [32w+31:32w].

Hit definition: `hit = valid[index] & (tag_array[index] == tag)`.

FSM states:
- IDLE:
  - `inst_resp = inst_read & hit`.
  - `inst_rdata` = selected word of the indexed line, driven regardless of hit.
  - If `inst_read & !hit`: latch `{tag,index,5'b0}` into the fill-address register, increment `miss_count`, and go to FILL.
- FILL:
  - `pmem_read = 1`; `pmem_address` = fill-address register; `inst_resp = 0`.
  - On `pmem_resp`: write `pmem_rdata` into data[fill index], write the fill tag, set valid, and go to IDLE.

Fill rules:
- A fill always completes, even if `inst_read` drops or `inst_addr` changes during FILL. The installed line is the latched address, not the current one.
- `pmem_resp` is ignored in IDLE.

Replacement: direct-mapped. A fill overwrites the indexed set unconditionally. There is no write path and no dirty state.

Counters:
- `hit_count` increments on every cycle in which `inst_resp = 1`, because the datapath may hold a request across a data stall.
- `miss_count` increments on each IDLE→FILL transition.
- Both saturate at 32'hFFFF_FFFF.

Reset (`rst` = 0), applied asynchronously:
- State → IDLE; all valid bits cleared.
- Data and tag arrays cleared to 0.
- Fill-address register and both counters cleared to 0.
- Outputs while in reset: `inst_resp=0`, `inst_rdata=0`, `pmem_read=0`, `pmem_address=0`, `hit_count=0`, `miss_count=0`.
- If reset asserts during FILL, the in-flight fill is abandoned. A later `pmem_resp` arriving in IDLE is ignored.

## Timing
- Hit latency is 0 cycles: `inst_resp` and `inst_rdata` are combinational from `inst_addr` and the arrays in the same cycle as `inst_read`.
- Miss sequence, with cycle 0 = the first request cycle:
  - Cycle 0: `inst_resp=0`.
  - Cycles 1..k: `pmem_read=1`, with `pmem_resp` arriving in cycle k.
  - Cycle k+1: state is IDLE, the line is valid, `inst_resp=1`, `pmem_read=0`.
  - Total miss penalty = k+1 cycles.
- `pmem_read` is held high with a stable `pmem_address` from cycle 1 until the cycle containing `pmem_resp` inclusive. It drops in the next cycle.
- The cache accepts no new request while in FILL. The datapath holds the PC while `inst_read & !inst_resp`.
- A back-to-back miss is possible: if the cycle-(k+1) address misses in another set, FILL is re-entered at the next edge.
- Cache-side outputs during FILL:
  - `inst_resp` is 0 on every FILL cycle.
  - `pmem_address` is stable for all FILL cycles.
  - `inst_rdata` continues to show the indexed line for the current address.

## Test plan
- Reset: hold `rst=0` for 3 cycles with `inst_read=1`, `inst_addr=0x60` → `inst_resp=0`, `pmem_read=0`, both counters 0. Release reset → miss begins: `pmem_read=1` at the next cycle, `pmem_address=0x60`.
- Cold miss then hits:
  - Read 0x64 with pmem latency 3 (`pmem_resp` in the 3rd FILL cycle), line word1 = 0xDEADBEEF → `inst_resp=1` with 0xDEADBEEF exactly 4 cycles after the request; `miss_count=1`.
  - Then read 0x7C → same-cycle `inst_resp` returning word7; `hit_count` increments.
- Conflict eviction (S_INDEX=4): fill 0x0000_0040, then 0x0000_0240 (same index 2, different tag) → second access misses and `pmem_address=0x240`. Re-reading 0x40 misses again; `miss_count=3`.
- Request withdrawn: drop `inst_read` and change `inst_addr` to 0x100 during FILL for 0x80 → fill still completes with `pmem_address=0x80`. A later read of 0x84 hits with 0 latency.
- Reset mid-fill: assert `rst=0` while `pmem_read=1`, then pulse `pmem_resp` after release → no valid bit set. A read of the same address misses; `miss_count` restarts from 1.
- Saturation: preload or force `hit_count` to 0xFFFF_FFFE and hold a hitting request for 3 cycles → count ends at 0xFFFF_FFFF and does not wrap.

Source files
------------

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped, read-only instruction cache with zero-latency
// hits, a two-state line-fill FSM and saturating hit/miss counters.
module inst_cache #(
  parameter int S_INDEX = 4,
  parameter int S_TAG   = 32 - 5 - S_INDEX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inst_read,
  input  logic [31:0]  inst_addr,
  output logic         inst_resp,
  output logic [31:0]  inst_rdata,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int SETS = 1 << S_INDEX;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fill_addr_q, fill_addr_d;
  logic [31:0]        hit_cnt_q, hit_cnt_d;
  logic [31:0]        miss_cnt_q, miss_cnt_d;
  logic [SETS-1:0]    valid_q;
  logic [S_TAG-1:0]   tag_q  [SETS];
  logic [255:0]       data_q [SETS];

  logic [S_TAG-1:0]   req_tag;
  logic [S_INDEX-1:0] req_idx;
  logic [2:0]         req_word;
  logic [S_TAG-1:0]   fill_tag;
  logic [S_INDEX-1:0] fill_idx;
  logic               hit;
  logic               miss_start;
  logic               fill_done;
  logic               unused_byte_sel;

  assign req_tag  = inst_addr[31:5+S_INDEX];
  assign req_idx  = inst_addr[4+S_INDEX:5];
  assign req_word = inst_addr[4:2];
  // Byte offset within the word is irrelevant for 32-bit instruction fetch.
  assign unused_byte_sel = ^inst_addr[1:0];

  assign fill_tag = fill_addr_q[31:5+S_INDEX];
  assign fill_idx = fill_addr_q[4+S_INDEX:5];

  assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign inst_rdata = data_q[req_idx][{req_word, 5'b00000} +: 32];

  // Next-state and request-side outputs of the miss FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    inst_resp   = 1'b0;
    pmem_read   = 1'b0;
    miss_start  = 1'b0;
    fill_done   = 1'b0;
    case (state_q)
      IDLE: begin
        inst_resp = inst_read && hit;
        if (inst_read && !hit) begin
          state_d     = FILL;
          fill_addr_d = {req_tag, req_idx, 5'b00000};
          miss_start  = 1'b1;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The fill address register is only loaded on a miss, so it stays stable throughout FILL.
  assign pmem_address = fill_addr_q;

  // Saturating performance counters.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (inst_resp && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_d = hit_cnt_q + 32'd1;
    if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // FSM state, fill address and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fill_addr_q <= 32'd0;
      hit_cnt_q   <= 32'd0;
      miss_cnt_q  <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Flop-based line storage; a completed fill overwrites the latched set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the arrays are flops, not RAM, so they can and do take the async reset.
      valid_q <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill_done) begin
      valid_q[fill_idx] <= 1'b1;
      tag_q[fill_idx]   <= fill_tag;
      data_q[fill_idx]  <= pmem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: self-checking bench for inst_cache with a behavioural line
// memory, a response scoreboard, a hit/no-hit vector table and miss sequences.
module tb_inst_cache;

  logic         clk;
  logic         rst;
  logic         inst_read;
  logic [31:0]  inst_addr;
  logic         inst_resp;
  logic [31:0]  inst_rdata;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic        exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  inst_cache dut (
    .clk          (clk),
    .rst          (rst),
    .inst_read    (inst_read),
    .inst_addr    (inst_addr),
    .inst_resp    (inst_resp),
    .inst_rdata   (inst_rdata),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: each word is its own address XOR a marker, except 0x64.
  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (wa == 32'h0000_0064) return 32'hDEAD_BEEF;
    return wa ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [255:0] gen_line(input logic [31:0] la);
    logic [255:0] line;
    logic [31:0]  base;
    base = {la[31:5], 5'b00000};
    for (int w = 0; w < 8; w++) line[32*w +: 32] = model_word(base + 32'(4 * w));
    return line;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    inst_read = 1'b0;
    pmem_resp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Issue one fetch, act as memory with the given latency, score the response.
  task automatic fetch(input logic [31:0] addr, input int lat, output int cycles);
    int fill_cyc;
    logic [31:0] line_addr;
    line_addr = {addr[31:5], 5'b00000};
    sb_q.push_back(model_word(addr));
    inst_read = 1'b1;
    inst_addr = addr;
    fill_cyc  = 0;
    cycles    = -1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (pmem_read) begin
        fill_cyc++;
        check("fill_addr", pmem_address, line_addr);
        if (fill_cyc == lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = gen_line(line_addr);
        end
      end
      #1;
      if (inst_resp) begin
        check("resp_rdata", inst_rdata, sb_q.pop_front());
        check("resp_pmem_read", 32'(pmem_read), 32'd0);
        cycles = c;
        @(negedge clk);
        pmem_resp = 1'b0;
        break;
      end
      @(negedge clk);
      pmem_resp = 1'b0;
    end
    if (cycles < 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL fetch_timeout: addr %h got no response within 40 cycles", addr);
      void'(sb_q.pop_front());
      inst_read = 1'b0;
    end
  endtask

  vec_t vecs[9];
  int   cyc;

  initial begin
    rst        = 1'b0;
    inst_read  = 1'b1;
    inst_addr  = 32'h0000_0060;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;

    // Reset held with a pending request: everything quiet.
    repeat (3) @(negedge clk);
    #1;
    check("rst_resp", 32'(inst_resp), 32'd0);
    check("rst_rdata", inst_rdata, 32'd0);
    check("rst_pmem_read", 32'(pmem_read), 32'd0);
    check("rst_pmem_addr", pmem_address, 32'd0);
    check("rst_hit_cnt", hit_count, 32'd0);
    check("rst_miss_cnt", miss_count, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_pmem_read", 32'(pmem_read), 32'd1);
    check("post_rst_pmem_addr", pmem_address, 32'h0000_0060);
    pmem_resp  = 1'b1;
    pmem_rdata = gen_line(32'h0000_0060);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    check("post_rst_resp", 32'(inst_resp), 32'd1);
    check("post_rst_rdata", inst_rdata, model_word(32'h0000_0060));
    check("post_rst_miss_cnt", miss_count, 32'd1);

    // Cold miss with latency 3, then a same-line hit.
    reset_dut();
    fetch(32'h0000_0064, 3, cyc);
    check("cold_latency", 32'(cyc), 32'd4);
    check("cold_miss_cnt", miss_count, 32'd1);
    check("cold_hit_cnt", hit_count, 32'd1);
    fetch(32'h0000_007C, 0, cyc);
    check("hit_latency", 32'(cyc), 32'd0);
    check("hit_hit_cnt", hit_count, 32'd2);

    // Conflict eviction in set 2.
    reset_dut();
    fetch(32'h0000_0040, 2, cyc);
    check("conf_a_latency", 32'(cyc), 32'd3);
    fetch(32'h0000_0240, 2, cyc);
    check("conf_b_latency", 32'(cyc), 32'd3);
    fetch(32'h0000_0040, 2, cyc);
    check("conf_a2_latency", 32'(cyc), 32'd3);
    check("conf_miss_cnt", miss_count, 32'd3);

    // Table of single-cycle lookups over a few preloaded lines.
    reset_dut();
    fetch(32'h0000_0000, 1, cyc);
    fetch(32'h0000_0020, 1, cyc);
    fetch(32'h0000_01A0, 1, cyc);
    fetch(32'h0000_03E0, 1, cyc);
    check("preload_latency", 32'(cyc), 32'd2);
    vecs[0] = '{1'b1, 32'h0000_0000, 1'b1, model_word(32'h0000_0000)};
    vecs[1] = '{1'b1, 32'h0000_001C, 1'b1, model_word(32'h0000_001C)};
    vecs[2] = '{1'b1, 32'h0000_0023, 1'b1, model_word(32'h0000_0020)};
    vecs[3] = '{1'b1, 32'h0000_01B4, 1'b1, model_word(32'h0000_01B4)};
    vecs[4] = '{1'b1, 32'h0000_03FC, 1'b1, model_word(32'h0000_03FC)};
    vecs[5] = '{1'b0, 32'h0000_003C, 1'b0, model_word(32'h0000_003C)};
    vecs[6] = '{1'b0, 32'h0000_0220, 1'b0, model_word(32'h0000_0020)};
    vecs[7] = '{1'b0, 32'h1000_0004, 1'b0, model_word(32'h0000_0004)};
    vecs[8] = '{1'b0, 32'h0000_0040, 1'b0, 32'h0000_0000};
    for (int i = 0; i < 9; i++) begin
      inst_read = vecs[i].rd;
      inst_addr = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_resp", i), 32'(inst_resp), 32'(vecs[i].exp_resp));
      check($sformatf("vec%0d_rdata", i), inst_rdata, vecs[i].exp_rdata);
      @(negedge clk);
    end
    inst_read = 1'b0;
    check("table_hit_cnt", hit_count, 32'd9);

    // Request withdrawn mid-fill: the latched line still installs.
    reset_dut();
    inst_read = 1'b1;
    inst_addr = 32'h0000_0080;
    #1;
    check("wd_req_resp", 32'(inst_resp), 32'd0);
    @(negedge clk);
    inst_read = 1'b0;
    inst_addr = 32'h0000_0100;
    #1;
    check("wd_fill_read", 32'(pmem_read), 32'd1);
    check("wd_fill_addr", pmem_address, 32'h0000_0080);
    @(negedge clk);
    #1;
    check("wd_fill_addr2", pmem_address, 32'h0000_0080);
    check("wd_fill_resp", 32'(inst_resp), 32'd0);
    pmem_resp  = 1'b1;
    pmem_rdata = gen_line(32'h0000_0080);
    @(negedge clk);
    #1;
    check("wd_idle_read", 32'(pmem_read), 32'd0);
    // A stray response while idle must not touch the arrays.
    pmem_rdata = ~gen_line(32'h0000_0080);
    @(negedge clk);
    pmem_resp = 1'b0;
    fetch(32'h0000_0084, 0, cyc);
    check("wd_hit_latency", 32'(cyc), 32'd0);
    check("wd_miss_cnt", miss_count, 32'd1);

    // Reset during FILL abandons the fill.
    reset_dut();
    inst_read = 1'b1;
    inst_addr = 32'h0000_00A0;
    @(negedge clk);
    #1;
    check("mf_fill_read", 32'(pmem_read), 32'd1);
    rst = 1'b0;
    #1;
    check("mf_rst_read", 32'(pmem_read), 32'd0);
    check("mf_rst_miss_cnt", miss_count, 32'd0);
    inst_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = gen_line(32'h0000_00A0);
    @(negedge clk);
    pmem_resp = 1'b0;
    fetch(32'h0000_00A0, 1, cyc);
    check("mf_refetch_latency", 32'(cyc), 32'd2);
    check("mf_miss_cnt", miss_count, 32'd1);

    // Hit counter saturation.
    inst_read = 1'b1;
    inst_addr = 32'h0000_00A4;
    #1;
    force dut.hit_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt_q;
    check("sat_preload", hit_count, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("sat_resp%0d", i), 32'(inst_resp), 32'd1);
      check($sformatf("sat_cnt%0d", i), hit_count, 32'hFFFF_FFFF);
    end
    inst_read = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
